pi1_rr_arb: RTL and testbench
=============================

# pi1_rr_arb

Round-robin arbiter that shares one PI1 slave port among MASTERCOUNT PI1 masters. It sits in front of the PI1-to-Wishbone bridge, or any PI1 slave, and lets several cores or DMA engines reach one memory or peripheral path. Grant is registered and changes only at transaction boundaries, so an in-flight operation is never split or misrouted.

## Interface
- MASTERCOUNT, 2, number of PI1 masters (≥2).
- ARCHBITSZ, 16, data width. ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- m_pi1_op_i  in  2*MASTERCOUNT  per-master op; master i at bits [2i+1:2i].
- m_pi1_addr_i  in  ADDRBITSZ*MASTERCOUNT  per-master word address.
- m_pi1_data_i  in  ARCHBITSZ*MASTERCOUNT  per-master write data.
- m_pi1_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  per-master byte select.
- m_pi1_data_o  out  ARCHBITSZ*MASTERCOUNT  per-master read data.
- m_pi1_rdy_o  out  MASTERCOUNT  per-master ready.
- s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o  out  slave-side request, with the same widths as one master slice.
- s_pi1_data_i  in  ARCHBITSZ  slave read data.
- s_pi1_rdy_i  in  1  slave ready.
- busy_o  out  1  a transaction is outstanding at the slave.

## Operation
- The PI1 op encoding is NOOP=00, WR=01, RD=10, RW=11.
- A transaction is accepted in any cycle where `op != NOOP` and rdy=1 at the slave.
- Its response, and acceptance of the next op, occur in the next cycle where slave rdy=1.
- State registers:
  - `gnt`: clog2(MASTERCOUNT) bits, reset 0.
  - `outstanding`: 1 bit, reset 0. Drives `busy_o`.
- Muxing:
  - The slave request fields are taken from master `gnt`.
  - `m_pi1_rdy_o[gnt] = s_pi1_rdy_i`. All other masters see rdy=0.
  - `m_pi1_data_o[gnt] = s_pi1_data_i`. All other masters see zero data.
- An op presented by a non-granted master is never forwarded. It must hold until that master sees rdy=1.
- Boundary cycle: any cycle with `s_pi1_rdy_i = 1`.
  - If `op[gnt] != NOOP`, the op is accepted and `outstanding <= 1`. `gnt` holds, so back-to-back ops from one master stream with no bubble.
  - If `op[gnt] == NOOP`, then `outstanding <= 0`. `gnt` moves to the first index j in the order gnt+1, gnt+2, …, gnt+MASTERCOUNT-1 (mod MASTERCOUNT) with `op[j] != NOOP`. If no such j exists, `gnt` holds.
- Outside a boundary cycle (slave rdy=0), `gnt` and `outstanding` hold.
- In RW transactions the slave data returned on the final rdy is passed through unchanged.

## Timing
- While `rst_i` is low, all outputs are forced combinationally:
  - `s_pi1_op_o` = NOOP; address, data and sel = 0.
  - `m_pi1_rdy_o` = 0 and `m_pi1_data_o` = 0.
  - `busy_o` = 0.
- Asserting reset mid-transaction drops the transaction. The slave is reset by the same signal.
- Muxing is combinational, with zero added latency on request and response paths. Only `gnt` and `outstanding` are registered.
- Grant-switch cost is exactly 1 cycle: on the boundary cycle where the old master is NOOP, the new master's op reaches the slave in the next cycle.
- Worst-case wait for a requesting master: every other master completes its current burst. Starvation is possible only if a master never issues NOOP. That is by design; masters must insert NOOP between bursts.
- Simultaneous requests at a switch are resolved strictly by round-robin order from gnt+1.

## Structure
- A shared include `lib/pi1.v` holds the PI1 op localparams (PINOOP, PIWROP, PIRDOP, PIRWOP). It is reused by every PI1 block.
- Use the existing `lib/clog2.v` for width computation.
- One sub-module, `rr_pick`. It is combinational: inputs are a request vector and the current index; output is the next index plus a found flag. It is parameterized by MASTERCOUNT and is reusable by other arbiters.
- The top level holds the muxes, the two registers and the boundary logic.

## Test plan
- Reset: hold `rst_i`=0 with master 1 at op=RD → `s_pi1_op_o`=00, all rdy=0, `busy_o`=0. After release, `gnt`=0.
- Single master: master 0 issues RD at address 0x10, slave returns 0xBEEF after 3 rdy-low cycles → `m_pi1_data_o[0]`=0xBEEF on the rdy cycle. Master 1 data=0 and rdy=0 throughout.
- Contention: masters 0 and 1 both request RD; master 0 then issues NOOP → on the boundary cycle the slave op=00, and the next cycle the slave sees master 1's address and op.
- Streaming: master 0 issues 4 back-to-back WR ops with slave rdy always 1 while master 1 waits → 4 consecutive slave WR cycles with no bubble. Master 1 is granted 1 cycle after master 0 goes NOOP.
- Rotation with MASTERCOUNT=3, gnt=1, masters 0 and 2 requesting at the boundary → gnt=2, then 0 after master 2 goes NOOP.
- RW through the bridge: master 1 RW at an address holding 0x1234 with write data 0x5678 → master 1 receives 0x1234 and memory holds 0x5678. `busy_o`=1 from acceptance until the response cycle.

Source files
------------

// File: rtl/pi1_rr_arb_pkg.sv
// Shared PI1 definitions for the round-robin arbiter and its picker.
// Covers the op encoding and the index-width helpers.
package pi1_rr_arb_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi1_op_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // A single-master index still needs one bit so the ports stay legal.
  function automatic int idxw(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pi1_rr_arb_rr_pick.sv
// Combinational round-robin picker: the first requester after cur_i, in
// wrap-around order. found_o is low when nobody else is requesting.
module rr_pick
  import pi1_rr_arb_pkg::*;
#(
  parameter int MASTERCOUNT = 2,
  localparam int IW = idxw(MASTERCOUNT)
) (
  input  logic [MASTERCOUNT-1:0] req_i,
  input  logic [IW-1:0]          cur_i,
  output logic [IW-1:0]          nxt_o,
  output logic                   found_o
);

  // cand[k] is the index that sits k+1 places after cur_i.
  logic [IW-1:0] cand [MASTERCOUNT-1];

  genvar gi;
  for (gi = 1; gi < MASTERCOUNT; gi++) begin : g_cand
    assign cand[gi-1] = IW'((int'(cur_i) + gi) % MASTERCOUNT);
  end

  always_comb begin
    nxt_o   = cur_i;
    found_o = 1'b0;
    for (int k = MASTERCOUNT - 2; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        nxt_o   = cand[k];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi1_rr_arb.sv
// Round-robin arbiter sharing one PI1 slave port among several PI1 masters.
// The grant only moves on a ready cycle where the granted master is idle.
module pi1_rr_arb
  import pi1_rr_arb_pkg::*;
#(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 16,
  localparam int SELW       = ARCHBITSZ / 8,
  localparam int ADDRBITSZ  = ARCHBITSZ - clog2(SELW),
  localparam int IW         = idxw(MASTERCOUNT)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2*MASTERCOUNT-1:0]         m_pi1_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i,
  input  logic [SELW*MASTERCOUNT-1:0]      m_pi1_sel_i,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_o,
  output logic [MASTERCOUNT-1:0]           m_pi1_rdy_o,
  output logic [1:0]                       s_pi1_op_o,
  output logic [ADDRBITSZ-1:0]             s_pi1_addr_o,
  output logic [ARCHBITSZ-1:0]             s_pi1_data_o,
  output logic [SELW-1:0]                  s_pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]             s_pi1_data_i,
  input  logic                             s_pi1_rdy_i,
  output logic                             busy_o
);

  logic [IW-1:0]          gnt_q, gnt_d;
  logic                   outstanding_q, outstanding_d;
  logic [MASTERCOUNT-1:0] req;
  logic [1:0]             gnt_op;
  logic [IW-1:0]          pick_idx;
  logic                   pick_found;

  genvar gi;
  for (gi = 0; gi < MASTERCOUNT; gi++) begin : g_req
    assign req[gi] = (m_pi1_op_i[2*gi +: 2] != PINOOP);
  end

  assign gnt_op = m_pi1_op_i[2*gnt_q +: 2];

  rr_pick #(
    .MASTERCOUNT(MASTERCOUNT)
  ) u_pick (
    .req_i  (req),
    .cur_i  (gnt_q),
    .nxt_o  (pick_idx),
    .found_o(pick_found)
  );

  // An accepted op pins the grant, so a streaming master keeps the port.
  always_comb begin
    gnt_d         = gnt_q;
    outstanding_d = outstanding_q;
    if (s_pi1_rdy_i) begin
      if (gnt_op != PINOOP) begin
        outstanding_d = 1'b1;
      end else begin
        outstanding_d = 1'b0;
        if (pick_found) gnt_d = pick_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_q         <= '0;
      outstanding_q <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Everything is gated off while reset is held so the slave sees NOOP.
  always_comb begin
    s_pi1_op_o   = PINOOP;
    s_pi1_addr_o = '0;
    s_pi1_data_o = '0;
    s_pi1_sel_o  = '0;
    m_pi1_rdy_o  = '0;
    m_pi1_data_o = '0;
    busy_o       = 1'b0;
    if (rst_i) begin
      s_pi1_op_o   = gnt_op;
      s_pi1_addr_o = m_pi1_addr_i[ADDRBITSZ*gnt_q +: ADDRBITSZ];
      s_pi1_data_o = m_pi1_data_i[ARCHBITSZ*gnt_q +: ARCHBITSZ];
      s_pi1_sel_o  = m_pi1_sel_i[SELW*gnt_q +: SELW];
      m_pi1_rdy_o[gnt_q] = s_pi1_rdy_i;
      m_pi1_data_o[ARCHBITSZ*gnt_q +: ARCHBITSZ] = s_pi1_data_i;
      busy_o       = outstanding_q;
    end
  end

endmodule

// File: tb/tb_pi1_rr_arb.sv
// Bench for pi1_rr_arb with three masters: vector table for grant/busy
// sequencing, plus hand sequences for latency, RW and async reset.
module tb_pi1_rr_arb;
  import pi1_rr_arb_pkg::*;

  localparam int MC  = 3;
  localparam int AW  = 16;
  localparam int SW  = 2;
  localparam int ADW = 15;
  localparam int NV  = 18;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [2*MC-1:0]   m_op;
  logic [ADW*MC-1:0] m_addr;
  logic [AW*MC-1:0]  m_wdata;
  logic [SW*MC-1:0]  m_sel;
  logic [AW*MC-1:0]  m_rdata;
  logic [MC-1:0]     m_rdy;
  logic [1:0]        s_op;
  logic [ADW-1:0]    s_addr;
  logic [AW-1:0]     s_wdata;
  logic [SW-1:0]     s_sel;
  logic [AW-1:0]     s_rdata;
  logic              s_rdy;
  logic              busy;

  logic [1:0]     mop   [MC];
  logic [ADW-1:0] maddr [MC];
  logic [AW-1:0]  mwd   [MC];
  logic [SW-1:0]  msel  [MC];

  typedef struct {
    logic [5:0] op;
    logic       srdy;
    logic [1:0] gnt;
    logic       busy;
  } vec_t;
  vec_t tbl [NV];

  logic [AW-1:0] mem [logic [ADW-1:0]];
  logic [AW-1:0] sb_q [$];
  logic [1:0]    g;
  logic [MC-1:0] er;
  logic [AW*MC-1:0] ed;
  logic [AW-1:0] rsp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    m_op    = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_sel   = '0;
    for (int i = 0; i < MC; i++) begin
      m_op[2*i +: 2]      = mop[i];
      m_addr[ADW*i +: ADW] = maddr[i];
      m_wdata[AW*i +: AW] = mwd[i];
      m_sel[SW*i +: SW]   = msel[i];
    end
  end

  pi1_rr_arb #(
    .MASTERCOUNT(MC),
    .ARCHBITSZ  (AW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m_pi1_op_i  (m_op),
    .m_pi1_addr_i(m_addr),
    .m_pi1_data_i(m_wdata),
    .m_pi1_sel_i (m_sel),
    .m_pi1_data_o(m_rdata),
    .m_pi1_rdy_o (m_rdy),
    .s_pi1_op_o  (s_op),
    .s_pi1_addr_o(s_addr),
    .s_pi1_data_o(s_wdata),
    .s_pi1_sel_o (s_sel),
    .s_pi1_data_i(s_rdata),
    .s_pi1_rdy_i (s_rdy),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [AW-1:0] act);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0h expected <empty scoreboard>", name, act);
    end else begin
      chk(name, {48'h0, act}, {48'h0, sb_q.pop_front()});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < MC; i++) mop[i] = PINOOP;
  endtask

  initial begin
    // {m2,m1,m0} ops, slave rdy, expected grant, expected busy
    tbl[0]  = '{6'b00_00_00, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{6'b00_10_10, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{6'b00_10_10, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{6'b00_10_10, 1'b0, 2'd0, 1'b1};
    tbl[4]  = '{6'b00_10_00, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{6'b00_10_00, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{6'b11_00_01, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{6'b11_00_01, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{6'b11_00_01, 1'b1, 2'd2, 1'b0};
    tbl[9]  = '{6'b00_00_01, 1'b1, 2'd2, 1'b1};
    tbl[10] = '{6'b00_00_01, 1'b1, 2'd0, 1'b0};
    tbl[11] = '{6'b00_00_01, 1'b1, 2'd0, 1'b1};
    tbl[12] = '{6'b00_10_00, 1'b0, 2'd0, 1'b1};
    tbl[13] = '{6'b00_10_00, 1'b1, 2'd0, 1'b1};
    tbl[14] = '{6'b00_00_00, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{6'b00_00_10, 1'b1, 2'd1, 1'b0};
    tbl[16] = '{6'b00_00_10, 1'b1, 2'd0, 1'b0};
    tbl[17] = '{6'b00_00_00, 1'b1, 2'd0, 1'b1};

    mem[15'h010] = 16'hBEEF;
    mem[15'h021] = 16'h1234;
    for (int i = 0; i < MC; i++) begin
      maddr[i] = ADW'(16 + 17 * i);
      mwd[i]   = AW'(16'hA000 + i);
      msel[i]  = SW'(i + 1);
    end
    idle_all();
    mop[1]  = PIRDOP;
    s_rdy   = 1'b1;
    s_rdata = 16'hDEAD;
    rst_i   = 1'b0;

    // Reset held: every output forced quiet despite a requesting master.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_s_op", {62'h0, s_op}, 64'h0);
    chk("rst_s_addr", {49'h0, s_addr}, 64'h0);
    chk("rst_s_data", {48'h0, s_wdata}, 64'h0);
    chk("rst_s_sel", {62'h0, s_sel}, 64'h0);
    chk("rst_m_rdy", {61'h0, m_rdy}, 64'h0);
    chk("rst_m_data", {16'h0, m_rdata}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    $display("reset s_op=%b m_rdy=%b busy=%b", s_op, m_rdy, busy);
    idle_all();
    rst_i = 1'b1;
    tick();

    for (int r = 0; r < NV; r++) begin
      for (int i = 0; i < MC; i++) mop[i] = tbl[r].op[2*i +: 2];
      s_rdy   = tbl[r].srdy;
      s_rdata = AW'(16'hC000 + r);
      #2;
      g  = tbl[r].gnt;
      er = '0;
      er[g] = s_rdy;
      ed = '0;
      ed[AW*g +: AW] = s_rdata;
      chk($sformatf("v%0d_s_op", r), {62'h0, s_op}, {62'h0, mop[g]});
      chk($sformatf("v%0d_s_addr", r), {49'h0, s_addr}, {49'h0, maddr[g]});
      chk($sformatf("v%0d_s_data", r), {48'h0, s_wdata}, {48'h0, mwd[g]});
      chk($sformatf("v%0d_s_sel", r), {62'h0, s_sel}, {62'h0, msel[g]});
      chk($sformatf("v%0d_m_rdy", r), {61'h0, m_rdy}, {61'h0, er});
      chk($sformatf("v%0d_m_data", r), {16'h0, m_rdata}, {16'h0, ed});
      chk($sformatf("v%0d_busy", r), {63'h0, busy}, {63'h0, tbl[r].busy});
      $display("vec %0d op=%b rdy=%b s_op=%b m_rdy=%b busy=%b", r, m_op, s_rdy, s_op, m_rdy, busy);
      tick();
    end

    // Master 0 read with three wait cycles before the response.
    idle_all();
    mop[0]  = PIRDOP;
    s_rdy   = 1'b1;
    s_rdata = '0;
    #2;
    chk("rd_accept_op", {62'h0, s_op}, {62'h0, PIRDOP});
    chk("rd_accept_addr", {49'h0, s_addr}, 64'h10);
    sb_q.push_back(mem[15'h010]);
    rsp = mem[s_addr];
    tick();
    mop[0] = PINOOP;
    s_rdy  = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #2;
      chk($sformatf("rd_wait%0d_rdy", w), {61'h0, m_rdy}, 64'h0);
      chk($sformatf("rd_wait%0d_busy", w), {63'h0, busy}, 64'h1);
      chk($sformatf("rd_wait%0d_m1data", w), {48'h0, m_rdata[AW +: AW]}, 64'h0);
      tick();
    end
    s_rdy   = 1'b1;
    s_rdata = rsp;
    #2;
    chk("rd_rsp_rdy", {61'h0, m_rdy}, 64'h1);
    sb_pop("rd_rsp_data", m_rdata[AW-1:0]);
    chk("rd_rsp_m1data", {48'h0, m_rdata[AW +: AW]}, 64'h0);
    chk("rd_rsp_busy", {63'h0, busy}, 64'h1);
    $display("read m0 data=%h rdy=%b", m_rdata[AW-1:0], m_rdy);
    tick();
    #2;
    chk("rd_after_busy", {63'h0, busy}, 64'h0);

    // Master 1 RW: receives old memory contents, memory takes new data.
    mwd[1] = 16'h5678;
    mop[1] = PIRWOP;
    #1;
    chk("rw_switch_op", {62'h0, s_op}, 64'h0);
    chk("rw_switch_busy", {63'h0, busy}, 64'h0);
    tick();
    #2;
    chk("rw_accept_op", {62'h0, s_op}, {62'h0, PIRWOP});
    chk("rw_accept_addr", {49'h0, s_addr}, 64'h21);
    chk("rw_accept_busy", {63'h0, busy}, 64'h0);
    sb_q.push_back(16'h1234);
    rsp = mem[s_addr];
    mem[s_addr] = s_wdata;
    tick();
    mop[1] = PINOOP;
    s_rdy  = 1'b0;
    #2;
    chk("rw_wait_busy", {63'h0, busy}, 64'h1);
    tick();
    s_rdy   = 1'b1;
    s_rdata = rsp;
    #2;
    chk("rw_rsp_rdy", {61'h0, m_rdy}, 64'h2);
    sb_pop("rw_rsp_data", m_rdata[AW +: AW]);
    chk("rw_rsp_busy", {63'h0, busy}, 64'h1);
    tick();
    #2;
    chk("rw_done_busy", {63'h0, busy}, 64'h0);
    chk("rw_mem", {48'h0, mem[15'h021]}, 64'h5678);
    $display("rw m1 data=%h mem=%h", rsp, mem[15'h021]);

    // Asynchronous reset in the middle of a master 2 transaction.
    mop[2] = PIRDOP;
    tick();
    tick();
    #1;
    chk("ar_pre_busy", {63'h0, busy}, 64'h1);
    chk("ar_pre_rdy", {61'h0, m_rdy}, 64'h4);
    rst_i = 1'b0;
    #1;
    chk("ar_busy", {63'h0, busy}, 64'h0);
    chk("ar_s_op", {62'h0, s_op}, 64'h0);
    chk("ar_m_rdy", {61'h0, m_rdy}, 64'h0);
    idle_all();
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    mop[2] = PIRDOP;
    #2;
    chk("ar_gnt0_op", {62'h0, s_op}, 64'h0);
    chk("ar_gnt0_rdy", {61'h0, m_rdy}, 64'h1);
    $display("async reset s_op=%b m_rdy=%b busy=%b", s_op, m_rdy, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
